// File: rtl/adc_i2s_receiver.sv
// Serial audio ADC receiver: deserialises left/right samples from an I2S or
// left-justified stream and hands each complete stereo pair to a consumer.
module adc_i2s_receiver #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1,
    parameter int DELAY     = 1
) (
    input  logic             i_BCLK,
    input  logic             i_rst,
    input  logic             i_record,
    input  logic             i_ADCLRCK,
    input  logic             i_ADCDAT,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_left,
    output logic [WIDTH-1:0] o_right,
    output logic             o_valid,
    output logic             o_overrun,
    output logic             o_frame_err,
    output logic [2:0]       o_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC  = 3'd1,
        SKIP  = 3'd2,
        SHIFT = 3'd3,
        HOLD  = 3'd4
    } state_t;

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state, state_d;
    logic             lrck_q, edge_c;
    logic             chan, chan_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [WIDTH-1:0] sr, sr_d;
    logic [WIDTH-1:0] lstage, lstage_d;
    logic             lstage_v, lstage_v_d;
    logic [WIDTH-1:0] left_d, right_d;
    logic             valid_d, overrun_d, frame_err_d;
    logic             start, done;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
        if (MSB_FIRST) return {cur[WIDTH-2:0], b};
        else           return {b, cur[WIDTH-1:1]};
    endfunction

    assign edge_c  = (i_ADCLRCK != lrck_q);
    assign o_state = state;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        state_d     = state;
        chan_d      = chan;
        cnt_d       = cnt;
        sr_d        = sr;
        lstage_d    = lstage;
        lstage_v_d  = lstage_v;
        left_d      = o_left;
        right_d     = o_right;
        valid_d     = o_valid;
        overrun_d   = o_overrun;
        frame_err_d = o_frame_err;
        start       = 1'b0;
        done        = 1'b0;

        // A transfer retires the current pair unless a new one replaces it below.
        if (o_valid && i_ready) valid_d = 1'b0;

        if (state != IDLE && !i_record) begin
            state_d    = IDLE;
            cnt_d      = '0;
            lstage_v_d = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_d      = '0;
                    lstage_v_d = 1'b0;
                    if (i_record) begin
                        state_d     = SYNC;
                        overrun_d   = 1'b0;
                        frame_err_d = 1'b0;
                    end
                end
                SYNC, HOLD: if (edge_c) start = 1'b1;
                SKIP: state_d = SHIFT;
                SHIFT: begin
                    if (edge_c) begin
                        frame_err_d = 1'b1;
                        start       = 1'b1;
                    end else begin
                        sr_d  = shift_in(sr, i_ADCDAT);
                        cnt_d = cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            done    = 1'b1;
                            state_d = HOLD;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            if (start) begin
                chan_d = i_ADCLRCK;
                if (DELAY == 0) begin
                    sr_d    = shift_in(sr, i_ADCDAT);
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end else begin
                    cnt_d   = '0;
                    state_d = SKIP;
                end
            end

            // Left samples wait in staging; a right sample only forms a pair with a staged left.
            if (done) begin
                if (!chan) begin
                    lstage_d   = sr_d;
                    lstage_v_d = 1'b1;
                end else if (lstage_v) begin
                    lstage_v_d = 1'b0;
                    if (!o_valid || i_ready) begin
                        left_d  = lstage;
                        right_d = sr_d;
                        valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_BCLK or posedge i_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (i_rst) begin
            // NOTE: the sample registers are reset too, so outputs and staging are deterministic after reset.
            state       <= IDLE;
            lrck_q      <= 1'b0;
            chan        <= 1'b0;
            cnt         <= '0;
            sr          <= '0;
            lstage      <= '0;
            lstage_v    <= 1'b0;
            o_left      <= '0;
            o_right     <= '0;
            o_valid     <= 1'b0;
            o_overrun   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            state       <= state_d;
            lrck_q      <= i_ADCLRCK;
            chan        <= chan_d;
            cnt         <= cnt_d;
            sr          <= sr_d;
            lstage      <= lstage_d;
            lstage_v    <= lstage_v_d;
            o_left      <= left_d;
            o_right     <= right_d;
            o_valid     <= valid_d;
            o_overrun   <= overrun_d;
            o_frame_err <= frame_err_d;
        end
    end

endmodule
